// File: rtl/ex_mem_latch_if.sv
// EX/MEM pipeline-register bundle: EX-side inputs and MEM-side registered outputs.
// The master drives EX results; the slave (the latch) returns the MEM view.
interface ex_mem_latch_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  localparam int unsigned CW = 32;

  logic          stall;
  logic          flush;
  logic          ex_valid;
  logic [1:0]    ctlwb_in;
  logic [2:0]    ctlm_in;
  logic [DW-1:0] add_result;
  logic          zero;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] rdata2;
  logic [RW-1:0] dest_reg;

  logic          mem_valid;
  logic [1:0]    wb_ctlout;
  logic          branch;
  logic          memread;
  logic          memwrite;
  logic [DW-1:0] add_result_out;
  logic          zero_out;
  logic [DW-1:0] alu_result_out;
  logic [DW-1:0] rdata2_out;
  logic [RW-1:0] dest_reg_out;
  logic          pcsrc;
  logic [CW-1:0] inst_count;
  logic [CW-1:0] flush_count;

  modport master (
    output stall, flush, ex_valid, ctlwb_in, ctlm_in, add_result, zero,
           alu_result, rdata2, dest_reg,
    input  mem_valid, wb_ctlout, branch, memread, memwrite, add_result_out,
           zero_out, alu_result_out, rdata2_out, dest_reg_out, pcsrc,
           inst_count, flush_count
  );

  modport slave (
    input  stall, flush, ex_valid, ctlwb_in, ctlm_in, add_result, zero,
           alu_result, rdata2, dest_reg,
    output mem_valid, wb_ctlout, branch, memread, memwrite, add_result_out,
           zero_out, alu_result_out, rdata2_out, dest_reg_out, pcsrc,
           inst_count, flush_count
  );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with bubble/flush/stall handling, a registered
// branch-taken select, and instruction/flush event counters.
module ex_mem_latch #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic         clk,
  input  logic         rst,
  ex_mem_latch_if.slave bus
);
  localparam int unsigned CW = 32;

  logic          mem_valid_q,  mem_valid_d;
  logic [1:0]    wb_q,         wb_d;
  logic [2:0]    m_q,          m_d;
  logic [DW-1:0] add_q,        add_d;
  logic          zero_q,       zero_d;
  logic [DW-1:0] alu_q,        alu_d;
  logic [DW-1:0] rdata2_q,     rdata2_d;
  logic [RW-1:0] dest_q,       dest_d;
  logic [CW-1:0] inst_count_q, inst_count_d;
  logic [CW-1:0] flush_count_q, flush_count_d;

  // One action per edge: flush beats stall beats load; reset handled in the flop.
  always_comb begin
    mem_valid_d   = mem_valid_q;
    wb_d          = wb_q;
    m_d           = m_q;
    add_d         = add_q;
    zero_d        = zero_q;
    alu_d         = alu_q;
    rdata2_d      = rdata2_q;
    dest_d        = dest_q;
    inst_count_d  = inst_count_q;
    flush_count_d = flush_count_q;
    if (bus.flush) begin
      mem_valid_d   = 1'b0;
      wb_d          = 2'b00;
      m_d           = 3'b000;
      add_d         = '0;
      zero_d        = 1'b0;
      alu_d         = '0;
      rdata2_d      = '0;
      dest_d        = '0;
      flush_count_d = CW'(flush_count_q + CW'(1));
    end else if (!bus.stall) begin
      mem_valid_d = bus.ex_valid;
      wb_d        = bus.ex_valid ? bus.ctlwb_in : 2'b00;
      m_d         = bus.ex_valid ? bus.ctlm_in  : 3'b000;
      add_d       = bus.add_result;
      zero_d      = bus.zero;
      alu_d       = bus.alu_result;
      rdata2_d    = bus.rdata2;
      dest_d      = bus.dest_reg;
      if (bus.ex_valid) begin
        inst_count_d = CW'(inst_count_q + CW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q   <= 1'b0;
      wb_q          <= 2'b00;
      m_q           <= 3'b000;
      add_q         <= '0;
      zero_q        <= 1'b0;
      alu_q         <= '0;
      rdata2_q      <= '0;
      dest_q        <= '0;
      inst_count_q  <= '0;
      flush_count_q <= '0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      wb_q          <= wb_d;
      m_q           <= m_d;
      add_q         <= add_d;
      zero_q        <= zero_d;
      alu_q         <= alu_d;
      rdata2_q      <= rdata2_d;
      dest_q        <= dest_d;
      inst_count_q  <= inst_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.mem_valid      = mem_valid_q;
  assign bus.wb_ctlout      = wb_q;
  assign bus.branch         = m_q[2];
  assign bus.memread        = m_q[1];
  assign bus.memwrite       = m_q[0];
  assign bus.add_result_out = add_q;
  assign bus.zero_out       = zero_q;
  assign bus.alu_result_out = alu_q;
  assign bus.rdata2_out     = rdata2_q;
  assign bus.dest_reg_out   = dest_q;
  assign bus.inst_count     = inst_count_q;
  assign bus.flush_count    = flush_count_q;
  // Branch select is formed only from latched state, never from EX inputs.
  assign bus.pcsrc          = m_q[2] & zero_q & mem_valid_q;
endmodule

// File: doc/ex_mem_latch.md
EX_MEM_LATCH -- requirements
Module: ex_mem_latch

Interface
REQ-001 Parameter: DW, 32, datapath width (ALU result, branch target, store data).
REQ-002 Parameter: RW, 5, register-specifier width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall  in  1  hold all registers (MEM stage busy).
REQ-007 flush  in  1  replace the latched instruction with a bubble.
REQ-008 ex_valid  in  1  EX stage presents a real instruction.
REQ-009 ctlwb_in  in  2  {RegWrite, MemtoReg}.
REQ-010 ctlm_in  in  3  {Branch, MemRead, MemWrite}.
REQ-011 add_result  in  DW  branch target from EX adder.
REQ-012 zero  in  1  ALU zero flag.
REQ-013 alu_result  in  DW  ALU output.
REQ-014 rdata2  in  DW  store data.
REQ-015 dest_reg  in  RW  selected destination register.
REQ-016 mem_valid  out  1; wb_ctlout  out  2; branch, memread, memwrite  out  1 each.
REQ-017 add_result_out, alu_result_out, rdata2_out  out  DW; zero_out  out  1; dest_reg_out  out  RW.
REQ-018 pcsrc  out  1  branch-taken select to the IF PC mux.
REQ-019 inst_count, flush_count  out  32  event counters.

Function
REQ-020 The block SHALL give each rising edge exactly one action, priority rst > flush > stall > load.
REQ-021 On load, all outputs SHALL equal the corresponding inputs one cycle later (latency 1).
REQ-022 On load with ex_valid=0, the block SHALL set mem_valid=0 and zero wb_ctlout/branch/memread/memwrite; data fields still load.
REQ-023 On load with ex_valid=1, the block SHALL set mem_valid=1 and load control fields unchanged.
REQ-024 On stall (flush=0), every output register and both counters SHALL hold.
REQ-025 On flush, the block SHALL clear mem_valid, all control outputs, zero_out, and all data outputs to 0, regardless of stall.
REQ-026 pcsrc SHALL be combinational from registers: branch & zero_out & mem_valid; never driven by unregistered inputs.
REQ-027 inst_count SHALL increment by 1 on each load with ex_valid=1.
REQ-028 flush_count SHALL increment by 1 on each flush edge (rst=0), including flush during stall.
REQ-029 Both counters SHALL wrap 0xFFFFFFFF -> 0x00000000 without a flag.
REQ-030 Sums and outputs SHALL be unsigned and width-exact; no sign extension inside the block.
REQ-031 Back-to-back flushes SHALL each count and keep outputs at 0.
REQ-032 A flush in the cycle after a taken branch (pcsrc=1) SHALL drop pcsrc to 0 on the next cycle.

Reset
REQ-033 With rst=1 at a rising edge, all outputs and both counters SHALL become 0 on that edge, overriding flush and stall.
REQ-034 Reset mid-stall SHALL discard the held instruction; the first edge after rst deasserts SHALL perform a normal load.
REQ-035 Before the first reset edge, output values are unspecified; the bench SHALL not check them.

Verification
REQ-036 Load: ex_valid=1, ctlm_in=3'b100, zero=1, add_result=0x00000040 -> next cycle branch=1, zero_out=1, pcsrc=1, add_result_out=0x00000040, inst_count=1.
REQ-037 Bubble: ex_valid=0, ctlwb_in=2'b11, alu_result=0x1234 -> mem_valid=0, wb_ctlout=0, alu_result_out=0x1234, inst_count unchanged.
REQ-038 Stall: load alu_result=0xA5A5A5A5, then stall=1 for 3 cycles while inputs change -> alu_result_out stays 0xA5A5A5A5, inst_count stays constant.
REQ-039 Flush+stall: stall=1, flush=1 with valid entry held -> next cycle all outputs 0, pcsrc=0, flush_count increments by 1.
REQ-040 Wrap/reset: force inst_count to 0xFFFFFFFF, one valid load -> 0x00000000; then rst=1 with flush=1 -> all outputs and both counters 0, flush_count not incremented.
